// File: rtl/crd_pair_arb.sv
// crd_pair_arb: round-robin arbiter that lends one shared coordinate
// hold/merge unit to NUM_REQ requesters. Each requester owns an outer (lane 0)
// and inner (lane 1) token stream. A grant is held for a whole tensor: it is
// released only once the DONE token has crossed on both lanes.

// One lane of the crossbar. It muxes the granted requester's stream onto the
// shared port and keeps a sticky per-lane "DONE seen" flag.
module crd_pair_arb_lane #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 17,
  parameter int GW      = 2,
  parameter logic [DW-1:0] DONE_TOK = 17'h10100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic                          busy,
  input  logic                          clr,
  input  logic [GW-1:0]                 gid,
  input  logic [NUM_REQ-1:0][DW-1:0]    req_crd,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DW-1:0]                 shr_crd,
  output logic                          shr_valid,
  input  logic                          shr_ready,
  output logic                          done,
  output logic                          done_xfer
);
  logic open;

  // A lane that has already passed its DONE stalls until the other lane catches up.
  assign open      = busy & ~done;
  assign shr_crd   = busy ? req_crd[gid] : '0;
  assign shr_valid = open & req_valid[gid];
  assign done_xfer = shr_valid & shr_ready & clk_en & (shr_crd == DONE_TOK);

  // Only the granted requester ever sees ready.
  always_comb begin
    req_ready = '0;
    if (open) req_ready[gid] = shr_ready;
  end

  // Sticky end-of-stream flag, wiped whenever no tensor is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          done <= 1'b0;
    else if (clk_en) begin
      if (clr)            done <= 1'b0;
      else if (done_xfer) done <= 1'b1;
    end
  end
endmodule

module crd_pair_arb #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 17,
  parameter logic [DW-1:0] DONE_TOK = 17'h10100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic                        tile_en,
  input  logic [16*NUM_REQ-1:0]       cfg_stop_lvl,
  input  logic [DW*NUM_REQ-1:0]       req_crd_in_0,
  input  logic [NUM_REQ-1:0]          req_crd_in_0_valid,
  output logic [NUM_REQ-1:0]          req_crd_in_0_ready,
  input  logic [DW*NUM_REQ-1:0]       req_crd_in_1,
  input  logic [NUM_REQ-1:0]          req_crd_in_1_valid,
  output logic [NUM_REQ-1:0]          req_crd_in_1_ready,
  output logic [DW-1:0]               shr_crd_out_0,
  output logic                        shr_crd_out_0_valid,
  input  logic                        shr_crd_out_0_ready,
  output logic [DW-1:0]               shr_crd_out_1,
  output logic                        shr_crd_out_1_valid,
  input  logic                        shr_crd_out_1_ready,
  output logic [15:0]                 shr_stop_lvl,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        grant_valid
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t  state_q, state_d;
  logic [GW-1:0] rr_q, rr_d, gid_q, gid_d, pick;
  logic          pick_any, busy, clr, both_done;
  logic [15:0]   stop_q;

  logic [NUM_REQ-1:0][15:0]          cfg;
  logic [1:0][NUM_REQ-1:0][DW-1:0]   crd_in;
  logic [1:0][NUM_REQ-1:0]           vld_in, rdy_out;
  logic [1:0][DW-1:0]                shr_crd;
  logic [1:0]                        shr_vld, shr_rdy, done, done_xfer;
  logic [NUM_REQ-1:0]                req_any;

  assign cfg       = cfg_stop_lvl;
  assign crd_in[0] = req_crd_in_0;
  assign crd_in[1] = req_crd_in_1;
  assign vld_in[0] = req_crd_in_0_valid;
  assign vld_in[1] = req_crd_in_1_valid;
  assign shr_rdy   = {shr_crd_out_1_ready, shr_crd_out_0_ready};
  assign req_any   = vld_in[0] | vld_in[1];

  // tile_en gates every handshake immediately, ahead of the FSM catching up.
  assign busy      = (state_q == BUSY) & tile_en;
  assign clr       = ~tile_en | (state_q == IDLE);
  assign both_done = &(done | done_xfer);

  for (genvar k = 0; k < 2; k++) begin : g_lane
    crd_pair_arb_lane #(
      .NUM_REQ(NUM_REQ), .DW(DW), .GW(GW), .DONE_TOK(DONE_TOK)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk_en    (clk_en),
      .busy      (busy),
      .clr       (clr),
      .gid       (gid_q),
      .req_crd   (crd_in[k]),
      .req_valid (vld_in[k]),
      .req_ready (rdy_out[k]),
      .shr_crd   (shr_crd[k]),
      .shr_valid (shr_vld[k]),
      .shr_ready (shr_rdy[k]),
      .done      (done[k]),
      .done_xfer (done_xfer[k])
    );
  end

  assign shr_crd_out_0       = shr_crd[0];
  assign shr_crd_out_1       = shr_crd[1];
  assign shr_crd_out_0_valid = shr_vld[0];
  assign shr_crd_out_1_valid = shr_vld[1];
  assign req_crd_in_0_ready  = rdy_out[0];
  assign req_crd_in_1_ready  = rdy_out[1];
  assign grant_id            = gid_q;
  assign grant_valid         = busy;
  assign shr_stop_lvl        = (state_q == BUSY) ? cfg[gid_q] : stop_q;

  // Round-robin pick: lowest requester at/after rr_q wins, else lowest overall.
  always_comb begin
    pick     = '0;
    pick_any = 1'b0;
    for (int r = NUM_REQ-1; r >= 0; r--)
      if (req_any[r]) begin
        pick     = GW'(r);
        pick_any = 1'b1;
      end
    for (int r = NUM_REQ-1; r >= 0; r--)
      if (req_any[r] && (r >= int'(rr_q))) pick = GW'(r);
  end

  // Next state: grant in IDLE, release after both DONEs, tile_en forces IDLE.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    if (!tile_en) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (pick_any) begin
          state_d = BUSY;
          gid_d   = pick;
        end
        BUSY: if (both_done) begin
          state_d = IDLE;
          rr_d    = (gid_q == GW'(NUM_REQ-1)) ? '0 : gid_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, pointer, grant and the stop level held across IDLE periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      stop_q  <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      if (state_q == BUSY) stop_q <= cfg[gid_q];
    end
  end
endmodule

// File: tb/tb_crd_pair_arb.sv
// Directed bench for crd_pair_arb. Requesters are fed from per-lane token
// queues; a transaction-level model (grant, per-lane done, rr pointer) predicts
// every handshake output each cycle, and literal logs pin the model itself.
module tb_crd_pair_arb;
  localparam int N  = 4;
  localparam int DW = 17;
  localparam logic [16:0] DONE = 17'h10100;

  logic clk = 1'b0;
  logic rst_n, clk_en, tile_en;
  logic [16*N-1:0] cfg;
  logic [DW*N-1:0] in0, in1;
  logic [N-1:0]    in0_v, in1_v, in0_r, in1_r;
  logic [DW-1:0]   o0, o1;
  logic            o0_v, o1_v, o0_r, o1_r, gv;
  logic [15:0]     stop;
  logic [1:0]      gid;

  crd_pair_arb #(.NUM_REQ(N), .DW(DW), .DONE_TOK(DONE)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .tile_en(tile_en),
    .cfg_stop_lvl(cfg),
    .req_crd_in_0(in0), .req_crd_in_0_valid(in0_v), .req_crd_in_0_ready(in0_r),
    .req_crd_in_1(in1), .req_crd_in_1_valid(in1_v), .req_crd_in_1_ready(in1_r),
    .shr_crd_out_0(o0), .shr_crd_out_0_valid(o0_v), .shr_crd_out_0_ready(o0_r),
    .shr_crd_out_1(o1), .shr_crd_out_1_valid(o1_v), .shr_crd_out_1_ready(o1_r),
    .shr_stop_lvl(stop), .grant_id(gid), .grant_valid(gv)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [16:0] q0 [N][$];
  logic [16:0] q1 [N][$];
  logic [16:0] olog0[$], olog1[$], glog[$];
  logic [16:0] e0[$], e1[$], eg[$];
  bit tog = 0, phase = 0;

  // model state
  bit m_busy, m_d0, m_d1;
  int m_g, m_rr;
  logic [15:0] m_stop;
  bit x0, x1;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_q(string nm, logic [16:0] got[$], logic [16:0] exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk(nm, got[i], exp[i]);
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      in0_v[r] = (q0[r].size() != 0);
      in1_v[r] = (q1[r].size() != 0);
      in0[r*DW +: DW] = in0_v[r] ? q0[r][0] : '0;
      in1[r*DW +: DW] = in1_v[r] ? q1[r][0] : '0;
    end
    phase = ~phase;
    o0_r = tog ? phase : 1'b1;
    o1_r = tog ? ~phase : 1'b1;
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    bit en, ev0, ev1;
    logic [N-1:0] er0, er1;
    drive();
    #1;
    en  = m_busy && tile_en;
    ev0 = en && in0_v[m_g] && !m_d0;
    ev1 = en && in1_v[m_g] && !m_d1;
    er0 = '0; er1 = '0;
    if (en && !m_d0 && o0_r) er0[m_g] = 1'b1;
    if (en && !m_d1 && o1_r) er1[m_g] = 1'b1;
    chk("grant_valid", gv, en);
    chk("grant_id", gid, m_g);
    chk("shr_v0", o0_v, ev0);
    chk("shr_v1", o1_v, ev1);
    chk("rdy0", in0_r, er0);
    chk("rdy1", in1_r, er1);
    if (ev0) chk("shr_crd0", o0, in0[m_g*DW +: DW]);
    if (ev1) chk("shr_crd1", o1, in1[m_g*DW +: DW]);
    chk("stop_lvl", stop, m_busy ? cfg[m_g*16 +: 16] : m_stop);
    x0 = ev0 && o0_r && clk_en;
    x1 = ev1 && o1_r && clk_en;
    if (x0) olog0.push_back(o0);
    if (x1) olog1.push_back(o1);
  end

  // Model advance: consume transferred tokens, then apply the grant rules.
  always @(posedge clk) begin
    bit t0, t1;
    int r;
    if (rst_n && clk_en) begin
      t0 = 0; t1 = 0;
      if (x0) t0 = (q0[m_g].pop_front() == DONE);
      if (x1) t1 = (q1[m_g].pop_front() == DONE);
      if (m_busy) m_stop = cfg[m_g*16 +: 16];
      if (!tile_en) begin
        m_busy = 0; m_d0 = 0; m_d1 = 0;
      end else if (!m_busy) begin
        m_d0 = 0; m_d1 = 0;
        for (int i = 0; i < N; i++) begin
          r = (m_rr + i) % N;
          if (!m_busy && (in0_v[r] || in1_v[r])) begin
            m_busy = 1; m_g = r; glog.push_back(17'(r));
          end
        end
      end else begin
        m_d0 = m_d0 | t0;
        m_d1 = m_d1 | t1;
        if (m_d0 && m_d1) begin
          m_busy = 0; m_rr = (m_g + 1) % N;
        end
      end
    end
  end

  task automatic model_reset();
    m_busy = 0; m_d0 = 0; m_d1 = 0; m_g = 0; m_rr = 0; m_stop = '0;
    x0 = 0; x1 = 0;
    for (int r = 0; r < N; r++) begin q0[r].delete(); q1[r].delete(); end
    olog0.delete(); olog1.delete(); glog.delete();
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(negedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    tog = 0; clk_en = 1'b1; tile_en = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_idle(string nm, int max);
    int n = 0;
    while (!(m_busy == 0 && olog_empty()) && n < max) begin tick(); n++; end
    if (n >= max) begin
      total++; bad++;
      $display("FAIL %s timeout after %0d cycles", nm, max);
    end
  endtask

  function automatic bit olog_empty();
    for (int r = 0; r < N; r++) if (q0[r].size() != 0 || q1[r].size() != 0) return 0;
    return 1;
  endfunction

  task automatic wait_busy(string nm, int max);
    int n = 0;
    while (!m_busy && n < max) begin tick(); n++; end
    if (!m_busy) begin
      total++; bad++;
      $display("FAIL %s no grant within %0d cycles", nm, max);
    end
  endtask

  initial begin
    rst_n = 1'b1; clk_en = 1'b1; tile_en = 1'b1;
    cfg = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    in0 = '0; in1 = '0; in0_v = '0; in1_v = '0; o0_r = 1'b1; o1_r = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_gv", gv, 0);   chk("rst_gid", gid, 0);
    chk("rst_v0", o0_v, 0); chk("rst_v1", o1_v, 0);
    chk("rst_r0", in0_r, 0); chk("rst_r1", in1_r, 0);
    chk("rst_stop", stop, 0);
    tick();
    rst_n = 1'b1;

    // 1: single requester, both lanes ending in DONE
    q0[0] = '{17'd5, 17'd7, 17'h10000, DONE};
    q1[0] = '{17'd1, 17'd2, 17'h10000, DONE};
    run_idle("t1", 40);
    e0 = '{17'd5, 17'd7, 17'h10000, DONE};
    e1 = '{17'd1, 17'd2, 17'h10000, DONE};
    chk_q("t1_lane0", olog0, e0);
    chk_q("t1_lane1", olog1, e1);
    eg = '{17'd0};
    chk_q("t1_grants", glog, eg);
    chk("t1_rr", m_rr, 1);

    // 2: all requesting one-token tensors, req0 has two
    do_reset();
    for (int r = 0; r < N; r++) begin q0[r].push_back(DONE); q1[r].push_back(DONE); end
    q0[0].push_back(DONE); q1[0].push_back(DONE);
    run_idle("t2", 60);
    eg = '{17'd0, 17'd1, 17'd2, 17'd3, 17'd0};
    chk_q("t2_grants", glog, eg);

    // 3: lane0 DONE three cycles ahead of lane1
    do_reset();
    q0[1] = '{17'h10, DONE, 17'h22, DONE};
    q1[1] = '{17'd1, 17'd2, 17'd3, 17'd4, DONE, 17'd5, DONE};
    wait_busy("t3", 10);
    tick(); tick();
    chk("t3_gap_rdy0", in0_r[1], 0);
    chk("t3_gap_v0", o0_v, 0);
    chk("t3_gap_rdy1", in1_r[1], 1);
    run_idle("t3", 40);
    e0 = '{17'h10, DONE, 17'h22, DONE};
    e1 = '{17'd1, 17'd2, 17'd3, 17'd4, DONE, 17'd5, DONE};
    chk_q("t3_lane0", olog0, e0);
    chk_q("t3_lane1", olog1, e1);
    eg = '{17'd1, 17'd1};
    chk_q("t3_grants", glog, eg);

    // 4: toggling shared ready, per-requester stop levels
    do_reset();
    cfg = {16'd3, 16'd2, 16'd1, 16'd0};
    tog = 1;
    e0.delete(); e1.delete();
    for (int r = 0; r < N; r++) begin
      q0[r] = '{17'(r*16+1), 17'(r*16+2), DONE};
      q1[r] = '{17'(r*16+5), DONE};
      e0.push_back(17'(r*16+1)); e0.push_back(17'(r*16+2)); e0.push_back(DONE);
      e1.push_back(17'(r*16+5)); e1.push_back(DONE);
    end
    run_idle("t4", 120);
    chk_q("t4_lane0", olog0, e0);
    chk_q("t4_lane1", olog1, e1);
    eg = '{17'd0, 17'd1, 17'd2, 17'd3};
    chk_q("t4_grants", glog, eg);
    chk("t4_stop_hold", stop, 16'd3);

    // 5: clk_en low while DONE is presented
    do_reset();
    cfg = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    q0[2] = '{17'd9, DONE};
    q1[2] = '{17'd8, DONE};
    wait_busy("t5", 10);
    tick();
    clk_en = 1'b0;
    repeat (4) tick();
    chk("t5_gv", gv, 1); chk("t5_gid", gid, 2);
    chk("t5_v0", o0_v, 1); chk("t5_crd0", o0, DONE);
    chk("t5_v1", o1_v, 1);
    clk_en = 1'b1;
    run_idle("t5", 20);
    e0 = '{17'd9, DONE}; e1 = '{17'd8, DONE};
    chk_q("t5_lane0", olog0, e0);
    chk_q("t5_lane1", olog1, e1);

    // 6: tile_en drop and reset pulse mid-tensor
    do_reset();
    q0[1] = '{DONE}; q1[1] = '{DONE};
    run_idle("t6a", 20);
    chk("t6_rr", m_rr, 2);
    q0[2] = '{17'h31, 17'h32, DONE};
    q1[2] = '{DONE, 17'h41, DONE};
    wait_busy("t6b", 10);
    tick();
    tile_en = 1'b0;
    #1;
    chk("t6_te_gv", gv, 0); chk("t6_te_v0", o0_v, 0);
    chk("t6_te_v1", o1_v, 0); chk("t6_te_r0", in0_r, 0);
    tick();
    tile_en = 1'b1;
    wait_busy("t6c", 10);
    tick();
    e0 = '{DONE, 17'h31, 17'h32};
    e1 = '{DONE, DONE, 17'h41};
    chk_q("t6_lane0", olog0, e0);
    chk_q("t6_lane1", olog1, e1);
    eg = '{17'd1, 17'd2, 17'd2};
    chk_q("t6_grants", glog, eg);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_gv", gv, 0); chk("t6_rst_gid", gid, 0);
    chk("t6_rst_v0", o0_v, 0); chk("t6_rst_r1", in1_r, 0);
    chk("t6_rst_stop", stop, 0);
    tick();
    rst_n = 1'b1;
    q0[0] = '{DONE}; q1[0] = '{DONE};
    q0[3] = '{DONE}; q1[3] = '{DONE};
    run_idle("t6d", 20);
    eg = '{17'd0, 17'd3};
    chk_q("t6_rst_grants", glog, eg);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
